// File: rtl/d_reg_pkg.sv
// Shared types and helpers for the round-robin shared D-register arbiter.
// Holds the FSM state encoding, default parameters and a minimum-1 width helper.
package d_reg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned DEF_N        = 4;
  localparam int unsigned DEF_W        = 8;
  localparam int unsigned DEF_MAX_HOLD = 4;

  // Bits needed to encode values 0..n-1, never less than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/d_reg_arbiter_rr_pick.sv
// Combinational round-robin finder: first set req bit at or after start, wrapping N-1 -> 0.
// Zero latency; found is low and idx is 0 when no bit is set.
module rr_pick
  import d_reg_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned IW = width_of(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [IW:0]    sum;

  always_comb begin
    dbl   = {req, req} >> start;
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    // Scan downwards so the bit closest to start is the last (winning) assignment.
    for (int k = N - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        found = 1'b1;
        sum   = {1'b0, start} + (IW+1)'(k);
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        idx   = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/d_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters; grant 1 cycle after req in IDLE.
// Granted requester writes q every cycle it keeps req high; a hold limit forces rotation.
module d_reg_arbiter
  import d_reg_pkg::*;
#(
  parameter  int unsigned N        = DEF_N,
  parameter  int unsigned W        = DEF_W,
  parameter  int unsigned MAX_HOLD = DEF_MAX_HOLD,
  localparam int unsigned IW       = width_of(N),
  localparam int unsigned HW       = width_of(MAX_HOLD + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  wdata,
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   owner,
  output logic [W-1:0]    q,
  output logic            q_valid
);

  state_e        state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] owner_q;
  logic [N-1:0]  gnt_q;
  logic [HW-1:0] hold_q;
  logic [W-1:0]  q_q;
  logic          q_valid_q;

  logic          own_req;
  logic          rel_drop;
  logic          rel_limit;
  logic [IW-1:0] owner_inc;
  logic [IW-1:0] pick_start;
  logic [N-1:0]  pick_req;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_oh;

  // gnt_q is zero when idle, so this alone qualifies a write.
  assign own_req   = |(req & gnt_q);
  assign rel_drop  = (state_q == BUSY) && !own_req;
  assign rel_limit = (state_q == BUSY) && own_req && (hold_q == HW'(MAX_HOLD));
  assign owner_inc = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

  // Searching from owner+1 puts the owner last, so on a limit release it wins only when alone.
  assign pick_start = (state_q == IDLE) ? ptr_q : owner_inc;
  assign pick_req   = rel_drop ? (req & ~gnt_q) : req;
  assign pick_oh    = {{(N-1){1'b0}}, 1'b1} << pick_idx;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      hold_q    <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      q_valid_q <= own_req;
      if (own_req) q_q <= wdata[owner_q*W +: W];

      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= BUSY;
            owner_q <= pick_idx;
            gnt_q   <= pick_oh;
            hold_q  <= HW'(1);
          end
        end
        BUSY: begin
          if (rel_drop || rel_limit) begin
            ptr_q <= owner_inc;
            if (pick_found) begin
              owner_q <= pick_idx;
              gnt_q   <= pick_oh;
              hold_q  <= HW'(1);
            end else begin
              state_q <= IDLE;
              owner_q <= '0;
              gnt_q   <= '0;
              hold_q  <= '0;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;

endmodule

// File: tb/tb_d_reg_arbiter.sv
// Self-checking bench for d_reg_arbiter: directed scenarios plus a randomized run
// compared against a tenure-level reference model.
module tb_d_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;
  localparam int IW = 2;
  localparam int WAIT_BOUND = (N - 1) * MH + 1;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [IW-1:0]  owner;
  logic [W-1:0]   q;
  logic           q_valid;

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 when idle), cycles in current tenure, search pointer.
  int         m_own;
  int         m_cnt;
  int         m_ptr;
  logic [W-1:0] m_q;
  logic       m_qv;

  d_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .owner   (owner),
    .q       (q),
    .q_valid (q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int find_from(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    return (m_own < 0) ? '0 : (N'(1) << m_own);
  endfunction

  function automatic logic [IW-1:0] exp_owner();
    return (m_own < 0) ? '0 : IW'(m_own);
  endfunction

  task automatic model_reset();
    m_own = -1; m_cnt = 0; m_ptr = 0; m_q = '0; m_qv = 1'b0;
  endtask

  task automatic model_edge();
    logic wr;
    wr = (m_own >= 0) && req[m_own];
    if (wr) m_q = wdata[m_own*W +: W];
    m_qv = wr;
    if (m_own < 0) begin
      m_own = find_from(req, m_ptr);
      m_cnt = 1;
    end else if (!wr || m_cnt == MH) begin
      m_ptr = (m_own + 1) % N;
      m_own = find_from(req, m_ptr);
      m_cnt = 1;
    end else begin
      m_cnt++;
    end
  endtask

  // Advance one edge; afterwards the phase is 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; wdata = '0;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; wdata = '0;
    model_reset();
    #2;
    checks += 4;
    if (gnt !== '0)    begin errors++; $display("FAIL reset_gnt got %b exp 0", gnt); end
    if (owner !== '0)  begin errors++; $display("FAIL reset_owner got %0d exp 0", owner); end
    if (q !== '0)      begin errors++; $display("FAIL reset_q got %h exp 0", q); end
    if (q_valid !== 0) begin errors++; $display("FAIL reset_qv got %b exp 0", q_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0010; wdata = 32'h0000_3C00;
    tick(); tick(); tick();
    checks++;
    if (q !== 8'h3C) begin errors++; $display("FAIL midrst_pre_q got %h exp 3c", q); end
    #2 rst = 1'b0;
    #1;
    checks += 4;
    if (gnt !== '0)    begin errors++; $display("FAIL midrst_gnt got %b exp 0", gnt); end
    if (owner !== '0)  begin errors++; $display("FAIL midrst_owner got %0d exp 0", owner); end
    if (q !== '0)      begin errors++; $display("FAIL midrst_q got %h exp 0", q); end
    if (q_valid !== 0) begin errors++; $display("FAIL midrst_qv got %b exp 0", q_valid); end
    @(posedge clk); #1;
    model_reset();
    rst = 1'b1;
    tick();
    checks += 2;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL midrst_regrant got %b exp 0010", gnt); end
    if (q_valid !== 0)   begin errors++; $display("FAIL midrst_regrant_qv got %b exp 0", q_valid); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    wdata = $urandom;
    wdata[23:16] = 8'hA5;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks += 2;
      if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt c=%0d got %b exp 0100", c, gnt); end
      if (owner !== 2'd2)  begin errors++; $display("FAIL single_owner c=%0d got %0d exp 2", c, owner); end
      if (c >= 2) begin
        checks += 2;
        if (q !== 8'hA5)   begin errors++; $display("FAIL single_q c=%0d got %h exp a5", c, q); end
        if (q_valid !== 1) begin errors++; $display("FAIL single_qv c=%0d got %b exp 1", c, q_valid); end
      end else begin
        checks++;
        if (q_valid !== 0) begin errors++; $display("FAIL single_qv_first got %b exp 0", q_valid); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e;
    do_reset();
    req = 4'b1111;
    wdata = {8'd3, 8'd2, 8'd1, 8'd0};
    for (int c = 1; c <= 20; c++) begin
      tick();
      e = N'(1) << (((c - 1) / MH) % N);
      checks++;
      if (gnt !== e) begin errors++; $display("FAIL rr_gnt c=%0d got %b exp %b", c, gnt, e); end
      if (c >= 2) begin
        checks += 2;
        if (q !== W'(((c - 2) / MH) % N)) begin
          errors++; $display("FAIL rr_q c=%0d got %0d exp %0d", c, q, ((c - 2) / MH) % N);
        end
        if (q_valid !== 1) begin errors++; $display("FAIL rr_qv c=%0d got %b exp 1", c, q_valid); end
      end
    end
  endtask

  task automatic test_early_drop();
    do_reset();
    wdata = 32'h3300_0011;
    req = 4'b0001;
    tick();
    req = 4'b1001;
    tick(); tick();
    checks += 2;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL drop_hold_gnt got %b exp 0001", gnt); end
    if (q !== 8'h11)     begin errors++; $display("FAIL drop_hold_q got %h exp 11", q); end
    req = 4'b1000;
    tick();
    checks += 3;
    if (gnt !== 4'b1000) begin errors++; $display("FAIL drop_move_gnt got %b exp 1000", gnt); end
    if (q !== 8'h11)     begin errors++; $display("FAIL drop_keep_q got %h exp 11", q); end
    if (q_valid !== 0)   begin errors++; $display("FAIL drop_qv got %b exp 0", q_valid); end
    tick();
    checks += 2;
    if (q !== 8'h33)     begin errors++; $display("FAIL drop_new_q got %h exp 33", q); end
    if (q_valid !== 1)   begin errors++; $display("FAIL drop_new_qv got %b exp 1", q_valid); end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    wdata = $urandom;
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL wrap_idle got %b exp 0000", gnt); end
    req = 4'b0101;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_to0 got %b exp 0001", gnt); end
    req = 4'b0111;
    tick();
    req = 4'b0101;
    tick(); tick(); tick();
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_to2 got %b exp 0100", gnt); end
    for (int c = 0; c < 12; c++) begin
      tick();
      checks += 2;
      if (gnt[1] !== 1'b0) begin errors++; $display("FAIL skip_pulse c=%0d got %b exp x0xx", c, gnt); end
      if (gnt !== exp_gnt()) begin errors++; $display("FAIL skip_model c=%0d got %b exp %b", c, gnt, exp_gnt()); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] nreq;
    logic [W-1:0] qprev;
    logic         pw;
    int           wait_cnt [N];
    int           max_wait [N];
    do_reset();
    for (int i = 0; i < N; i++) begin wait_cnt[i] = 0; max_wait[i] = 0; end
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i])      nreq[i] = ($urandom_range(0, 4) != 0);
        else if (req[i]) nreq[i] = ($urandom_range(0, 29) != 0);
        else             nreq[i] = ($urandom_range(0, 2) == 0);
      end
      req   = nreq;
      wdata = {$urandom};
      pw    = |(gnt & req);
      qprev = q;
      tick();
      checks += 6;
      if (gnt !== exp_gnt())     begin errors++; $display("FAIL rnd_gnt c=%0d got %b exp %b", c, gnt, exp_gnt()); end
      if (owner !== exp_owner()) begin errors++; $display("FAIL rnd_owner c=%0d got %0d exp %0d", c, owner, exp_owner()); end
      if (q !== m_q)             begin errors++; $display("FAIL rnd_q c=%0d got %h exp %h", c, q, m_q); end
      if (q_valid !== m_qv)      begin errors++; $display("FAIL rnd_qv c=%0d got %b exp %b", c, q_valid, m_qv); end
      if (!$onehot0(gnt))        begin errors++; $display("FAIL rnd_onehot c=%0d got %b", c, gnt); end
      if ((q !== qprev) && !pw)  begin errors++; $display("FAIL rnd_q_unwritten c=%0d got %h was %h", c, q, qprev); end
      for (int i = 0; i < N; i++) begin
        if (req[i] && !gnt[i]) wait_cnt[i]++;
        else                   wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait[i]) max_wait[i] = wait_cnt[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (max_wait[i] > WAIT_BOUND) begin
        errors++; $display("FAIL rnd_starve req%0d got %0d exp <= %0d", i, max_wait[i], WAIT_BOUND);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mid_reset();
    test_single();
    test_round_robin();
    test_early_drop();
    test_wrap_skip();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
